// File: rtl/mac_mult_pkg.sv
// Shared types and helpers for the pipelined multiply-accumulate block.
package mac_mult_pkg;

    // Per-beat control that travels alongside the operands through every stage.
    typedef struct packed {
        logic valid;
        logic is_signed;
        logic acc;
        logic acc_clr;
    } mac_ctrl_t;

    localparam int CTRL_W = $bits(mac_ctrl_t);

    // Number of enabled cut points in a stage mask; latency is this plus one.
    function automatic int unsigned stage_count(input logic [63:0] mask);
        int unsigned n;
        logic [63:0] m;
        n = 0;
        m = mask;
        for (int i = 0; i < 64; i++) begin
            if (m[0]) n++;
            m = m >> 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/stall_pipe_reg.sv
// Optional pipeline cut point: a holding flop when enabled, a plain wire otherwise.
module stall_pipe_reg
    import mac_mult_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter bit ENABLE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (ENABLE) begin : g_reg
        logic [WIDTH-1:0] data_q;

        // Capture the upstream slot unless the whole pipe is stalled.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q <= '0;
            end else if (!hold_i) begin
                data_q <= d_i;
            end
        end

        assign q_o = data_q;
    end else begin : g_wire
        logic unused_ctl;
        assign unused_ctl = ^{clk, rst, hold_i};
        assign q_o        = d_i;
    end

endmodule

// File: rtl/pipelined_mac_multiplier.sv
// Signed/unsigned Baugh-Wooley array multiplier with optional accumulation,
// mask-selected pipeline cuts and a globally stalling valid/ready handshake.
module pipelined_mac_multiplier
    import mac_mult_pkg::*;
#(
    parameter int                 DATAWIDTH  = 8,
    parameter int                 ACC_WIDTH  = 2*DATAWIDTH + 8,
    parameter logic [DATAWIDTH:0] STAGE_MASK = (DATAWIDTH+1)'(1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic                 i_signed,
    input  logic                 i_acc,
    input  logic                 i_acc_clr,
    input  logic [DATAWIDTH-1:0] A,
    input  logic [DATAWIDTH-1:0] B,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [ACC_WIDTH-1:0] Z_final,
    output logic                 o_ovf
);

    localparam int PW = 2*DATAWIDTH;
    localparam int SW = CTRL_W + 2*DATAWIDTH + PW;
    // Baugh-Wooley correction constant 2^N + 2^(2N-1), seeded into the partial sum.
    localparam logic [PW-1:0] BW_CORR = (PW'(1) << DATAWIDTH) | (PW'(1) << (PW-1));

    // Add partial-product row j into a slot's running sum. For signed beats the
    // row bits that carry negative weight are inverted (Baugh-Wooley).
    function automatic logic [SW-1:0] row_add(input logic [SW-1:0] s, input int j);
        mac_ctrl_t              c;
        logic [DATAWIDTH-1:0]   a, b, sel, row, inv;
        logic [PW-1:0]          ps;
        logic                   b_bit;
        {c, a, b, ps} = s;
        sel   = DATAWIDTH'(1) << j;
        b_bit = |(b & sel);
        row   = a & {DATAWIDTH{b_bit}};
        inv   = '0;
        if (c.is_signed) begin
            if (j == DATAWIDTH-1) inv = {1'b0, {(DATAWIDTH-1){1'b1}}};
            else                  inv = {1'b1, {(DATAWIDTH-1){1'b0}}};
        end
        row = row ^ inv;
        ps  = ps + (PW'(row) << j);
        return {c, a, b, ps};
    endfunction

    // Overflow of an ACC_WIDTH add: two's-complement overflow or unsigned carry-out.
    function automatic logic ovf_of(input logic [ACC_WIDTH-1:0] x,
                                    input logic [ACC_WIDTH-1:0] y,
                                    input logic                 is_signed);
        logic [ACC_WIDTH:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (is_signed)
            return (x[ACC_WIDTH-1] == y[ACC_WIDTH-1]) && (s[ACC_WIDTH-1] != x[ACC_WIDTH-1]);
        return s[ACC_WIDTH];
    endfunction

    logic          stall;
    logic          o_valid_q, o_valid_d;
    logic [ACC_WIDTH-1:0] z_q, z_d, acc_q, acc_d;
    logic          ovf_q, ovf_d;

    assign stall   = o_valid_q && !o_ready;
    assign i_ready = !stall;

    // ---- stage 0: beat entry, optional operand register ----
    mac_ctrl_t     ctrl_in;
    logic [SW-1:0] stg_d [0:DATAWIDTH];
    logic [SW-1:0] stg_q [0:DATAWIDTH];

    assign ctrl_in  = '{valid: i_valid && i_ready, is_signed: i_signed,
                        acc: i_acc, acc_clr: i_acc_clr};
    assign stg_d[0] = {ctrl_in, A, B, (i_signed ? BW_CORR : PW'(0))};

    // ---- stages 1..N: one partial-product row each, optional cut after row k ----
    for (genvar k = 0; k <= DATAWIDTH; k++) begin : g_stage
        if (k > 0) begin : g_row
            assign stg_d[k] = row_add(stg_q[k-1], k-1);
        end
        stall_pipe_reg #(
            .WIDTH  (SW),
            .ENABLE (STAGE_MASK[k])
        ) u_cut (
            .clk    (clk),
            .rst    (rst),
            .hold_i (stall),
            .d_i    (stg_d[k]),
            .q_o    (stg_q[k])
        );
    end

    // ---- output stage: extension, accumulation, result register ----
    mac_ctrl_t                   fin_ctrl;
    logic [DATAWIDTH-1:0]        unused_fin_a, unused_fin_b;
    logic signed [PW-1:0]        fin_prod;
    logic signed [ACC_WIDTH-1:0] prod_sx;
    logic [ACC_WIDTH-1:0]        prod_ext, acc_sum;

    assign {fin_ctrl, unused_fin_a, unused_fin_b, fin_prod} = stg_q[DATAWIDTH];
    assign prod_sx  = ACC_WIDTH'(fin_prod);
    assign prod_ext = fin_ctrl.is_signed ? prod_sx : ACC_WIDTH'($unsigned(fin_prod));
    assign acc_sum  = acc_q + prod_ext;

    // Next-state for the result register; bubbles and stalls leave everything alone.
    always_comb begin
        o_valid_d = o_valid_q;
        z_d       = z_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        if (!stall) begin
            o_valid_d = fin_ctrl.valid;
            if (fin_ctrl.valid) begin
                if (!fin_ctrl.acc) begin
                    z_d = prod_ext;
                end else if (fin_ctrl.acc_clr) begin
                    acc_d = prod_ext;
                    z_d   = prod_ext;
                    ovf_d = 1'b0;
                end else begin
                    acc_d = acc_sum;
                    z_d   = acc_sum;
                    ovf_d = ovf_q | ovf_of(acc_q, prod_ext, fin_ctrl.is_signed);
                end
            end
        end
    end

    // Result, accumulator and sticky overflow registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid_q <= 1'b0;
            z_q       <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            o_valid_q <= o_valid_d;
            z_q       <= z_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
        end
    end

    assign o_valid = o_valid_q;
    assign Z_final = z_q;
    assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_pipelined_mac_multiplier.sv
// Directed bench for pipelined_mac_multiplier: default-mask and fully pipelined instances.
module tb_pipelined_mac_multiplier;
    import mac_mult_pkg::*;

    localparam int          DW       = 4;
    localparam int          AW       = 12;
    localparam logic [DW:0] MASK_DEF = 5'b00001;
    localparam logic [DW:0] MASK_ALL = 5'b11111;
    localparam int          L1       = int'(stage_count(64'(MASK_ALL))) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_signed, in_acc, in_clr;
    logic [DW-1:0] a_in, b_in;
    logic          or0, or1;
    logic          i_ready0, i_ready1, o_valid0, o_valid1, ovf0, ovf1;
    logic [AW-1:0] z0, z1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipelined_mac_multiplier #(.DATAWIDTH(DW), .ACC_WIDTH(AW), .STAGE_MASK(MASK_DEF)) dut0 (
        .clk(clk), .rst(rst), .i_valid(in_valid), .i_ready(i_ready0),
        .i_signed(in_signed), .i_acc(in_acc), .i_acc_clr(in_clr),
        .A(a_in), .B(b_in), .o_valid(o_valid0), .o_ready(or0),
        .Z_final(z0), .o_ovf(ovf0)
    );

    pipelined_mac_multiplier #(.DATAWIDTH(DW), .ACC_WIDTH(AW), .STAGE_MASK(MASK_ALL)) dut1 (
        .clk(clk), .rst(rst), .i_valid(in_valid), .i_ready(i_ready1),
        .i_signed(in_signed), .i_acc(in_acc), .i_acc_clr(in_clr),
        .A(a_in), .B(b_in), .o_valid(o_valid1), .o_ready(or1),
        .Z_final(z1), .o_ovf(ovf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic s, input logic acc, input logic clr);
        a_in = a; b_in = b; in_signed = s; in_acc = acc; in_clr = clr; in_valid = 1'b1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AW-1:0] exp_q[$];
        logic [AW-1:0] prev_z;
        logic          prev_stall;
        int            sent, got, stall_cnt, first_out, stale;

        rst = 1'b1; in_valid = 1'b0; in_signed = 1'b0; in_acc = 1'b0; in_clr = 1'b0;
        a_in = '0; b_in = '0; or0 = 1'b1; or1 = 1'b1;

        // Reset state
        tick();
        chk("rst_ovalid", o_valid0, 0);
        chk("rst_z", z0, 0);
        chk("rst_ovf", ovf0, 0);
        chk("rst_iready", i_ready0, 1);
        rst = 1'b0;
        tick();

        // Unsigned 15*15, latency 2
        beat(15, 15, 0, 0, 0); tick(); idle();
        chk("umul_ovalid_early", o_valid0, 0);
        tick();
        chk("umul_ovalid", o_valid0, 1);
        chk("umul_z", z0, 12'h0E1);
        tick();
        chk("umul_ovalid_drop", o_valid0, 0);

        // Signed corner cases, back to back
        beat(4'h8, 4'h8, 1, 0, 0); tick();
        beat(4'h8, 4'h7, 1, 0, 0); tick();
        chk("smul_m8m8", z0, 12'h040);
        idle(); tick();
        chk("smul_m8p7", z0, 12'hFC8);

        // Unsigned MAC sequence
        beat(3, 4, 0, 1, 1); tick();
        beat(5, 6, 0, 1, 0); tick();
        chk("mac_1", z0, 12);
        beat(2, 2, 0, 1, 0); tick();
        chk("mac_2", z0, 42);
        idle(); tick();
        chk("mac_3", z0, 46);

        // Signed accumulate with carry-out but no signed overflow
        beat(4'h8, 4'h7, 1, 1, 1); tick();
        beat(4'h8, 4'h8, 1, 1, 0); tick();
        chk("sacc_clr", z0, 12'hFC8);
        idle(); tick();
        chk("sacc_sum", z0, 12'h008);
        chk("sacc_no_ovf", ovf0, 0);

        // Unsigned overflow: 19 beats of 225
        for (int i = 0; i < 19; i++) begin
            beat(15, 15, 0, 1, (i == 0));
            tick();
            if (i == 18) begin
                chk("ovf_pre_z", z0, 4050);
                chk("ovf_pre_flag", ovf0, 0);
            end
        end
        idle(); tick();
        chk("ovf_z", z0, 179);
        chk("ovf_flag", ovf0, 1);

        // Clear drops the flag; a plain multiply does not disturb the accumulator
        beat(1, 1, 0, 1, 1); tick();
        beat(3, 3, 0, 0, 0); tick();
        chk("clr_z", z0, 1);
        chk("clr_ovf", ovf0, 0);
        beat(2, 2, 0, 1, 0); tick();
        chk("mix_plain", z0, 9);
        idle(); tick();
        chk("mix_acc", z0, 5);

        for (int i = 0; i < 8; i++) tick();

        // Backpressure on the fully pipelined instance
        sent = 0; got = 0; stall_cnt = 0; first_out = -1; prev_stall = 1'b0; prev_z = '0;
        for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
            or1 = !((cyc >= 7 && cyc < 10) || (cyc >= 14 && cyc < 17) || (cyc >= 21 && cyc < 24));
            if (sent < 20) beat(4'(sent*5 + 3), 4'(sent*3 + 1), 0, 0, 0);
            else           idle();
            #1;
            if (prev_stall) begin
                chk("bp_hold_valid", o_valid1, 1);
                chk("bp_hold_z", z1, prev_z);
            end
            chk("bp_iready", i_ready1, !(o_valid1 && !or1));
            if (o_valid1 && !or1) stall_cnt++;
            if (in_valid && i_ready1) begin
                exp_q.push_back(AW'(a_in) * AW'(b_in));
                sent++;
            end
            if (o_valid1 && or1) begin
                if (first_out < 0) first_out = cyc;
                if (exp_q.size() == 0) chk("bp_extra_out", exp_q.size(), 1);
                else                   chk("bp_z", z1, exp_q.pop_front());
                got++;
            end
            prev_stall = o_valid1 && !or1;
            prev_z     = z1;
            tick();
        end
        idle(); or1 = 1'b1;
        chk("bp_count", got, 20);
        chk("bp_leftover", exp_q.size(), 0);
        chk("bp_stall_cycles", stall_cnt, 9);
        chk("bp_latency", first_out, L1);

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            beat(4'(i + 1), 3, 0, 0, 0);
            tick();
        end
        idle();
        #2 rst = 1'b1;
        #1;
        chk("mrst_ovalid", o_valid1, 0);
        chk("mrst_z", z1, 0);
        chk("mrst_ovf", ovf1, 0);
        chk("mrst_iready", i_ready1, 1);
        chk("mrst_z0", z0, 0);
        tick();
        rst = 1'b0;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (o_valid1 || o_valid0) stale++;
        end
        chk("mrst_no_stale", stale, 0);

        // Accumulator was zeroed by reset
        beat(2, 3, 0, 1, 0); tick();
        idle(); tick();
        chk("mrst_acc_zero", z0, 6);
        chk("mrst_acc_ovf", ovf0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_mac_multiplier.md
# pipelined_mac_multiplier

Parametrised successor to the array multiplier. Multiplies signed or unsigned DATAWIDTH-bit operands and optionally accumulates products into an ACC_WIDTH-bit accumulator. Carries a valid/ready handshake with full backpressure, and pipeline register placement is set by a bitmask. It sits between an operand producer (FIFO or controller) and a result consumer in the datapath.

## Interface
- DATAWIDTH, 8, operand width (≥ 2)
- ACC_WIDTH, 2*DATAWIDTH+8, accumulator and result width (≥ 2*DATAWIDTH)
- STAGE_MASK, {(DATAWIDTH+1){1'b0}} | 1, register enable per cut point:
  - bit 0: operand input register
  - bit k (1..DATAWIDTH): after partial-product row k
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- i_valid  input  1  operand beat valid
- i_ready  output  1  block accepts a beat this cycle
- i_signed  input  1  1 = two's-complement operands, 0 = unsigned
- i_acc  input  1  1 = accumulate mode, 0 = plain multiply
- i_acc_clr  input  1  with i_acc = 1: load the accumulator with this product instead of adding
- A  input  DATAWIDTH  multiplicand
- B  input  DATAWIDTH  multiplier
- o_valid  output  1  result valid
- o_ready  input  1  consumer accepts the result
- Z_final  output  ACC_WIDTH  result
- o_ovf  output  1  sticky accumulator overflow flag

## Operation
- Beat transfer: a beat is accepted when i_valid && i_ready. i_signed, i_acc and i_acc_clr travel with the beat through every stage.
- Product: the array forms the full 2*DATAWIDTH product.
  - Unsigned: zero-extended to ACC_WIDTH.
  - Signed: Baugh-Wooley array, sign-extended to ACC_WIDTH.
- Output register: always present, independent of STAGE_MASK. When a beat advances into it:
  - i_acc = 0: Z_final = extended product; accumulator unchanged.
  - i_acc = 1, i_acc_clr = 1: acc = Z_final = product; o_ovf cleared to 0.
  - i_acc = 1, i_acc_clr = 0: acc = Z_final = acc + product, modulo 2^ACC_WIDTH.
    - o_ovf is set on signed overflow (i_signed = 1) or unsigned carry-out (i_signed = 0).
    - Once set, o_ovf holds until a clr beat or reset.
- Stall rule: stall = o_valid && !o_ready.
  - i_ready = !stall.
  - While stalled, every enabled register holds, including the valid bits and the accumulator.
  - There is no bubble collapsing: the pipeline stalls globally.
- Bubbles: an invalid slot moves forward but never updates the accumulator or o_ovf. Data regs in invalid slots may be gated to zero.
- Mode mixing: per-beat mode changes are legal. The accumulator reflects only acc beats, in arrival order.

## Timing
- Latency L = popcount(STAGE_MASK) + 1 cycles from accepted beat to o_valid. Default mask gives L = 2.
- Throughput: one beat per cycle when o_ready = 1.
- o_valid and Z_final stay stable while o_valid && !o_ready.
- Combinational paths: i_ready depends combinationally on o_ready (a single AND gate). No other input-to-output paths exist.
- Reset values: every valid bit = 0, o_valid = 0, Z_final = 0, accumulator = 0, o_ovf = 0. i_ready = 1 out of reset.
- Reset mid-stream: all in-flight beats are discarded and the accumulator is zeroed. No o_valid appears for pre-reset beats.
- Simultaneous events: when a beat enters the output register in the same cycle the old result is consumed, the old result is accepted and the new one replaces it with no gap.

## Structure
- Package mac_mult_pkg holds:
  - typedef mac_ctrl_t {valid, is_signed, acc, acc_clr}
  - function stage_count(mask), computing the popcount used for L
- Sub-module stall_pipe_reg, parameters WIDTH and ENABLE:
  - ENABLE = 1: async-reset flop with hold-on-stall.
  - ENABLE = 0: wire.
  - One instance per STAGE_MASK bit.

## Test plan
Unless noted: DATAWIDTH = 4, ACC_WIDTH = 12, default mask.
- Unsigned multiply: A = 15, B = 15, i_signed = 0, i_acc = 0 -> Z_final = 0x0E1, o_valid 2 cycles after acceptance.
- Signed multiply:
  - A = 4'h8, B = 4'h8 -> Z_final = 0x040.
  - A = 4'h8, B = 4'h7 -> Z_final = 0xFC8.
- MAC sequence: (3,4,clr), (5,6), (2,2), all unsigned accumulate -> Z_final = 12, 42, 46, in order.
- Overflow: clr beat 15*15, then 18 further unsigned acc beats of 15*15.
  - Final Z_final = 4275 - 4096 = 179, o_ovf = 1.
  - A following clr beat of 1*1 gives Z_final = 1, o_ovf = 0.
- Backpressure, mask = all ones (L = 6):
  - Stream 20 beats with o_ready low for 3 cycles at random points.
  - No loss or duplication, order preserved, Z_final stable while stalled, i_ready = 0 exactly during stall.
- Reset mid-stream: assert rst while 3 beats are in flight -> outputs at reset values within the same cycle, and no stale o_valid afterwards.
